// File: rtl/pool_memo_reader_1.sv
`timescale 1ns/1ps
// Read-side owner of the layer-1 pool memories: passes writer ports through
// while pooling, then sweeps all pooled word pairs into a valid/ready stream.
module pool_memo_reader_1 #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_MULT        = 4,
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int POOL_DEPTH      = 169,
    parameter int RD_LATENCY      = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pool_done,
    input  logic                             rd_start,
    input  logic [POOL_ADDR_WIDTH-1:0]       wr_address_a_t,
    input  logic [POOL_ADDR_WIDTH-1:0]       wr_address_b_t,
    input  logic                             wr_rden_a,
    input  logic                             wr_rden_b,
    input  logic                             wr_wren_a,
    input  logic                             wr_wren_b,
    output logic [POOL_ADDR_WIDTH-1:0]       address_a_t_use_out,
    output logic [POOL_ADDR_WIDTH-1:0]       address_b_t_use_out,
    output logic                             rden_a_use_out,
    output logic                             rden_b_use_out,
    output logic                             wren_a_use_out,
    output logic                             wren_b_use_out,
    input  logic [DATA_WIDTH*NUM_MULT-1:0]   q_a_all,
    input  logic [DATA_WIDTH*NUM_MULT-1:0]   q_b_all,
    output logic [2*DATA_WIDTH*NUM_MULT-1:0] out_data,
    output logic                             out_mask_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy
);

    localparam int AW        = POOL_ADDR_WIDTH;
    localparam int PW        = 2 * DATA_WIDTH * NUM_MULT;
    localparam int NUM_PAIRS = (POOL_DEPTH + 1) / 2;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_PAIR = AW'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        S_POOL,
        S_WAIT,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [AW-1:0]         pair_cnt;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_m;
    logic [RD_LATENCY-1:0] tag_l;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PW-1:0]         fifo_data [FIFO_DEPTH];
    logic                  fifo_mask [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];

    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          rd_has_b;
    logic          is_last;
    logic          issue;
    logic          emerge;
    logic          pop;

    always_comb begin
        rd_addr_a = pair_cnt << 1;
        rd_addr_b = rd_addr_a | AW'(1);
        rd_has_b  = int'(rd_addr_b) < POOL_DEPTH;
        is_last   = pair_cnt == LAST_PAIR;
        // Reserve FIFO room for every read still in the memory pipeline
        issue     = (state == S_READ) &&
                    ((int'(count) + int'(inflight)) < FIFO_DEPTH);
        emerge    = tag_v[RD_LATENCY-1];
        pop       = out_valid && out_ready;
    end

    always_comb begin
        address_a_t_use_out = '0;
        address_b_t_use_out = '0;
        rden_a_use_out      = 1'b0;
        rden_b_use_out      = 1'b0;
        wren_a_use_out      = 1'b0;
        wren_b_use_out      = 1'b0;
        unique case (state)
            S_POOL: begin
                address_a_t_use_out = wr_address_a_t;
                address_b_t_use_out = wr_address_b_t;
                rden_a_use_out      = wr_rden_a;
                rden_b_use_out      = wr_rden_b;
                wren_a_use_out      = wr_wren_a;
                wren_b_use_out      = wr_wren_b;
            end
            S_READ: begin
                address_a_t_use_out = rd_addr_a;
                address_b_t_use_out = rd_addr_b;
                rden_a_use_out      = issue;
                rden_b_use_out      = issue && rd_has_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_POOL;
            pair_cnt <= '0;
        end else begin
            unique case (state)
                S_POOL: if (pool_done) state <= S_WAIT;
                S_WAIT: begin
                    if (rd_start) begin
                        state    <= S_READ;
                        pair_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        if (is_last) state <= S_DRAIN;
                        else pair_cnt <= pair_cnt + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0 && count == '0) state <= S_WAIT;
                end
                default: state <= S_POOL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v    <= '0;
            tag_m    <= '0;
            tag_l    <= '0;
            inflight <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_m[i] <= tag_m[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            tag_v[0] <= issue;
            tag_m[0] <= rd_has_b;
            tag_l[0] <= is_last;
            case ({issue, emerge})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (emerge) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({emerge, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (emerge) begin
            fifo_data[wr_ptr] <= {q_b_all, q_a_all};
            fifo_mask[wr_ptr] <= tag_m[RD_LATENCY-1];
            fifo_last[wr_ptr] <= tag_l[RD_LATENCY-1];
        end
    end

    // Head fields are gated so an empty FIFO always presents zeros
    always_comb begin
        out_valid  = count != '0;
        out_data   = out_valid ? fifo_data[rd_ptr] : '0;
        out_mask_b = out_valid && fifo_mask[rd_ptr];
        out_last   = out_valid && fifo_last[rd_ptr];
        busy       = (state == S_READ) || (state == S_DRAIN);
    end

endmodule

// File: tb/tb_pool_memo_reader_1.sv
`timescale 1ns/1ps
// Directed bench for pool_memo_reader_1: mux vectors, full sweeps,
// backpressure, odd-depth boundary and mid-sweep reset.
module tb_pool_memo_reader_1;

    localparam int AW    = 10;
    localparam int NM    = 4;
    localparam int LAT   = 2;
    localparam int FD    = 4;
    localparam int PAIRS = 85;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          pool_done = 0, rd_start = 0;
    logic          pool_done3 = 0, rd_start3 = 0;
    logic [AW-1:0] wr_addr_a = '0, wr_addr_b = '0;
    logic          wr_rden_a = 0, wr_rden_b = 0, wr_wren_a = 0, wr_wren_b = 0;
    logic          out_ready = 1, out_ready3 = 1;

    logic [AW-1:0] addr_a, addr_b, addr_a3, addr_b3;
    logic          rden_a, rden_b, wren_a, wren_b;
    logic          rden_a3, rden_b3, wren_a3, wren_b3;
    logic [31:0]   q_a, q_b, q_a3, q_b3;
    logic [63:0]   out_data, out_data3;
    logic          out_mask_b, out_valid, out_last, busy;
    logic          out_mask_b3, out_valid3, out_last3, busy3;

    pool_memo_reader_1 dut (
        .clock(clk), .reset(rst_n), .pool_done(pool_done), .rd_start(rd_start),
        .wr_address_a_t(wr_addr_a), .wr_address_b_t(wr_addr_b),
        .wr_rden_a(wr_rden_a), .wr_rden_b(wr_rden_b),
        .wr_wren_a(wr_wren_a), .wr_wren_b(wr_wren_b),
        .address_a_t_use_out(addr_a), .address_b_t_use_out(addr_b),
        .rden_a_use_out(rden_a), .rden_b_use_out(rden_b),
        .wren_a_use_out(wren_a), .wren_b_use_out(wren_b),
        .q_a_all(q_a), .q_b_all(q_b), .out_data(out_data),
        .out_mask_b(out_mask_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    pool_memo_reader_1 #(.POOL_DEPTH(3)) dut3 (
        .clock(clk), .reset(rst_n), .pool_done(pool_done3), .rd_start(rd_start3),
        .wr_address_a_t(wr_addr_a), .wr_address_b_t(wr_addr_b),
        .wr_rden_a(wr_rden_a), .wr_rden_b(wr_rden_b),
        .wr_wren_a(wr_wren_a), .wr_wren_b(wr_wren_b),
        .address_a_t_use_out(addr_a3), .address_b_t_use_out(addr_b3),
        .rden_a_use_out(rden_a3), .rden_b_use_out(rden_b3),
        .wren_a_use_out(wren_a3), .wren_b_use_out(wren_b3),
        .q_a_all(q_a3), .q_b_all(q_b3), .out_data(out_data3),
        .out_mask_b(out_mask_b3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_last(out_last3), .busy(busy3)
    );

    // Two-cycle memory model: each lane returns its own address
    logic [AW-1:0] s1a = '0, s1b = '0, ma = '0, mb = '0;
    logic [AW-1:0] s1a3 = '0, s1b3 = '0, ma3 = '0, mb3 = '0;
    always @(posedge clk) begin
        s1a <= addr_a;   s1b <= addr_b;   ma <= s1a;   mb <= s1b;
        s1a3 <= addr_a3; s1b3 <= addr_b3; ma3 <= s1a3; mb3 <= s1b3;
    end
    assign q_a  = {NM{ma[7:0]}};
    assign q_b  = {NM{mb[7:0]}};
    assign q_a3 = {NM{ma3[7:0]}};
    assign q_b3 = {NM{mb3[7:0]}};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    int k = 0;
    int first_cyc = -1;
    int rs_cyc = 0;
    int issued = 0;
    int wren_bad = 0;
    bit mon_en = 0;

    always @(negedge clk) begin
        logic [31:0] ea, eb;
        if (busy && (wren_a || wren_b)) wren_bad++;
        if (busy3 && (wren_a3 || wren_b3)) wren_bad++;
        if (busy && rden_a) issued++;
        if (mon_en && out_valid) begin
            ea = {NM{8'(2 * k)}};
            eb = {NM{8'(2 * k + 1)}};
            chk("pair_a", {32'd0, out_data[31:0]}, {32'd0, ea});
            if (out_ready) begin
                if (k != PAIRS - 1)
                    chk("pair_b", {32'd0, out_data[63:32]}, {32'd0, eb});
                chk("mask_b", {63'd0, out_mask_b}, {63'd0, k != PAIRS - 1});
                chk("last", {63'd0, out_last}, {63'd0, k == PAIRS - 1});
                if (k == 0) first_cyc = cyc;
                k++;
            end
        end
    end

    logic [63:0] d3[$];
    bit          m3[$];
    bit          l3[$];
    bit          rb3[$];
    always @(negedge clk) begin
        if (out_valid3 && out_ready3) begin
            d3.push_back(out_data3);
            m3.push_back(out_mask_b3);
            l3.push_back(out_last3);
        end
        if (busy3 && rden_a3) rb3.push_back(rden_b3);
    end

    typedef struct {
        bit          in_wait;
        logic [AW-1:0] a, b;
        logic [3:0]  en;
        logic [AW-1:0] ea, eb;
        logic [3:0]  een;
    } vec_t;

    task automatic pulse_pd();
        @(posedge clk); #1 pool_done = 1;
        @(posedge clk); #1 pool_done = 0;
    endtask

    task automatic start_sweep();
        k = 0; issued = 0; first_cyc = -1; mon_en = 1;
        @(posedge clk); #1 rd_start = 1; rs_cyc = cyc;
        @(posedge clk); #1 rd_start = 0;
    endtask

    task automatic wait_k(input int target, input string name);
        int t;
        for (t = 0; t < 600; t++) begin
            @(posedge clk);
            if (k >= target) break;
        end
        if (t == 600) chk(name, 64'(k), 64'(target));
    endtask

    task automatic finish_sweep();
        wait_k(PAIRS, "sweep_timeout");
        chk("pair_count", 64'(k), 64'(PAIRS));
        chk("first_latency", 64'(first_cyc - rs_cyc), 64'(LAT + 2));
        @(negedge clk);
        @(negedge clk);
        chk("busy_drop", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        vec_t vt[4];
        vt[0] = '{0, 10'h155, 10'h0AA, 4'b1010, 10'h155, 10'h0AA, 4'b1010};
        vt[1] = '{0, 10'h3FF, 10'h001, 4'b0101, 10'h3FF, 10'h001, 4'b0101};
        vt[2] = '{1, 10'h123, 10'h321, 4'b1111, 10'h000, 10'h000, 4'b0000};
        vt[3] = '{1, 10'h0A8, 10'h3C3, 4'b0011, 10'h000, 10'h000, 4'b0000};

        wr_addr_a = 10'h2A;
        wr_wren_a = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_addr_a", 64'(addr_a), 64'h2A);
        chk("rst_wren_a", {63'd0, wren_a}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_flags", {62'd0, out_last, out_mask_b}, 64'd0);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (vt[i].in_wait == p[0]) begin
                    @(posedge clk); #1;
                    wr_addr_a = vt[i].a;
                    wr_addr_b = vt[i].b;
                    {wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b} = vt[i].en;
                    @(negedge clk);
                    chk("vec_addr", 64'({addr_a, addr_b}), 64'({vt[i].ea, vt[i].eb}));
                    chk("vec_en", 64'({rden_a, rden_b, wren_a, wren_b}), 64'(vt[i].een));
                end
            end
            if (p == 0) begin
                wr_rden_a = 0;
                @(posedge clk); #1 rd_start = 1;
                @(posedge clk); #1 rd_start = 0;
                repeat (6) @(negedge clk);
                chk("pool_rdstart_busy", {63'd0, busy}, 64'd0);
                chk("pool_rdstart_valid", {63'd0, out_valid}, 64'd0);
                chk("pool_rdstart_issue", 64'(issued), 64'd0);
                pulse_pd();
            end
        end

        @(posedge clk); #1 pool_done3 = 1;
        @(posedge clk); #1 pool_done3 = 0; rd_start3 = 1;
        @(posedge clk); #1 rd_start3 = 0;
        repeat (20) @(posedge clk);
        chk("odd_pairs", 64'(d3.size()), 64'd2);
        chk("odd_issues", 64'(rb3.size()), 64'd2);
        if (d3.size() >= 2 && rb3.size() >= 2) begin
            chk("odd_p0", d3[0], 64'h01010101_00000000);
            chk("odd_p0_flags", 64'({m3[0], l3[0]}), 64'b10);
            chk("odd_p1_a", {32'd0, d3[1][31:0]}, 64'h02020202);
            chk("odd_p1_flags", 64'({m3[1], l3[1]}), 64'b01);
            chk("odd_rden_b", 64'({rb3[0], rb3[1]}), 64'b10);
        end
        chk("odd_busy", {63'd0, busy3}, 64'd0);

        start_sweep();
        repeat (10) @(posedge clk);
        #1 pool_done = 1;
        @(posedge clk); #1 pool_done = 0;
        finish_sweep();

        start_sweep();
        wait_k(20, "bp_reach_timeout");
        #1 out_ready = 0;
        begin
            int base_k;
            base_k = k;
            repeat (20) @(posedge clk);
            #1;
            chk("bp_no_xfer", 64'(k), 64'(base_k));
            chk("bp_outstanding", 64'(issued - k <= FD), 64'd1);
        end
        out_ready = 1;
        finish_sweep();

        start_sweep();
        wait_k(10, "rst_reach_timeout");
        #1 wr_addr_a = 10'h15; wr_wren_a = 0;
        mon_en = 0;
        rst_n = 0;
        #1;
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_data", out_data, 64'd0);
        chk("mrst_flags", {62'd0, out_last, out_mask_b}, 64'd0);
        chk("mrst_addr_a", 64'(addr_a), 64'h15);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        pulse_pd();
        start_sweep();
        finish_sweep();

        chk("wren_outside_pool", 64'(wren_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_memo_reader_1.md
Name: pool_memo_reader_1

Overview:
- Read-side owner of the layer-1 pool memories.
- During pooling it forwards the pool writer's address and enable signals unchanged to the memory "use" ports.
- After conv/pool completion it takes the ports, sweeps every pooled word (two words per cycle on ports A and B), and presents them to the layer-2 input stage as a valid/ready stream through a small skid FIFO.
- It sits between layer_1 and the next layer's feature fetch.

Parameters:
- DATA_WIDTH, 8, width of one pooled feature word
- NUM_MULT, 4, number of parallel pool memories (lanes)
- POOL_ADDR_WIDTH, 10, pool memory address width
- POOL_DEPTH, 169, number of valid words per pool memory (13x13)
- RD_LATENCY, 2, cycles from rden/address to valid q at the memory
- FIFO_DEPTH, 4, skid FIFO entries (power of two, must be >= RD_LATENCY+1)

Ports:
- clock, in, 1, system clock
- reset, in, 1, asynchronous active-low reset
- pool_done, in, 1, one-cycle pulse: layer_1 pooling finished, memory contents final
- rd_start, in, 1, one-cycle pulse from consumer requesting a full sweep
- wr_address_a_t, in, POOL_ADDR_WIDTH, pool writer port-A address
- wr_address_b_t, in, POOL_ADDR_WIDTH, pool writer port-B address
- wr_rden_a / wr_rden_b / wr_wren_a / wr_wren_b, in, 1 each, pool writer enables
- address_a_t_use_out / address_b_t_use_out, out, POOL_ADDR_WIDTH, muxed memory addresses
- rden_a_use_out / rden_b_use_out / wren_a_use_out / wren_b_use_out, out, 1 each, muxed memory enables
- q_a_all, in, DATA_WIDTH*NUM_MULT, port-A read data, all lanes
- q_b_all, in, DATA_WIDTH*NUM_MULT, port-B read data, all lanes
- out_data, out, 2*DATA_WIDTH*NUM_MULT, {portB lanes, portA lanes} word pair
- out_mask_b, out, 1, 1 = upper half (port B) valid
- out_valid, out, 1, stream valid
- out_ready, in, 1, stream ready
- out_last, out, 1, asserted with final pair of a sweep
- busy, out, 1, high in READ or DRAIN

Behaviour:
- Reset: FSM=POOL; all counters and FIFO pointers = 0; out_valid=0, out_last=0, out_mask_b=0, busy=0, out_data=0. Port mux selects the writer during reset.

State POOL:
- use-port outputs = wr_* inputs combinationally; no reads issued.
- pool_done -> WAIT.

State WAIT:
- All use-port enables = 0; addresses = 0.
- rd_start -> READ. A rd_start that arrives in POOL is ignored.

State READ:
- Issue pair k: address_a = 2k, address_b = 2k+1, rden_a = 1, rden_b = 1 only if 2k+1 < POOL_DEPTH; wren_* = 0 always.
- Issue only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH. This guarantees the FIFO never overflows while out_ready is low.
- A RD_LATENCY-deep shift register of {valid, mask_b, last} tags tracks in-flight reads. When a tag emerges, capture {q_b_all, q_a_all} into the FIFO in that same cycle.
- After issuing pair ceil(POOL_DEPTH/2)-1 -> DRAIN.

State DRAIN:
- No issue. Wait until in-flight = 0 and FIFO empty, then -> WAIT. A new sweep needs a new rd_start.

Output handshake:
- out_valid = FIFO non-empty; a transfer happens when out_valid && out_ready.
- out_data, out_mask_b and out_last come from the FIFO head and are stable while out_valid && !out_ready.
- FIFO push and pop in the same cycle keep occupancy unchanged.
- Sweep sequence: POOL_DEPTH=169 gives 85 pairs. Pair 84 has out_mask_b=0 and out_last=1; in that pair out_data upper half is don't-care, and the bench must not check it.

Other rules:
- pool_done arriving in READ, DRAIN or WAIT is ignored.
- Returning to POOL needs reset; the next image begins with a reset pulse.
- Reset mid-sweep: FIFO and tags discarded immediately, outputs return to reset values asynchronously.
- Address counter width POOL_ADDR_WIDTH; POOL_DEPTH <= 2^POOL_ADDR_WIDTH, so no wrap occurs.
- busy = 1 in READ and DRAIN.

Test Plan:
- Reset/passthrough: hold reset low, drive wr_address_a_t=0x2A with wr_wren_a=1. Release reset: address_a_t_use_out=0x2A and wren_a_use_out=1 in the same cycle; out_valid=0.
- Full sweep: memory model returns q = address per lane, out_ready tied 1, pool_done then rd_start. Expect 85 transfers; the first appears RD_LATENCY+2 cycles after rd_start. Pair k has lanes A=2k and B=2k+1. The last pair has A=168, out_mask_b=0, out_last=1. busy drops within 2 cycles after the last transfer.
- Backpressure: out_ready low for 20 cycles mid-sweep. Issue stalls with at most FIFO_DEPTH pairs outstanding, no loss or duplication, out_data held stable. The resumed order is contiguous.
- Odd boundary: POOL_DEPTH=3. Exactly 2 pairs: (0,1) then (2,x) with mask_b=0, last=1. rden_b_use_out=0 on the second issue.
- Spurious controls: rd_start in POOL is ignored, no reads. pool_done in READ does not restart the sweep. wren_*_use_out is never 1 outside POOL.
- Reset mid-sweep: assert reset after 10 pairs. Outputs return to reset values immediately. After release, pool_done and rd_start give a full 85-pair sweep starting at address 0.
